i2s_capture: RTL
================

Name: i2s_capture

Overview:
- Upstream feeder for the audio engine.
- Deserialises up to 4 I2S data lines, 8 mono channels (left/right per line), into 16-bit samples.
- At each frame boundary, writes one sample per channel into the engine's audio input DP RAM at address {chan, frame}.
- Advances a 6-bit frame counter and pulses frame_done, which the engine uses for its reset/sequencer start.

Parameters:
- LINES, 4, number of I2S sd input lines (1..4); channels = 2*LINES.
- CHAN_W, 3, channel index width (log2 of 8 channels).
- FRAME_W, 6, frame counter width (64 frames of history).
- SAMPLE_W, 16, bits captured per slot (MSB-first).

Ports:
- ck  in  1  system clock; all logic on posedge ck.
- rst  in  1  asynchronous, active-low reset.
- sck  in  1  I2S bit clock, generated from ck by the I2S clock divider (synchronous to ck).
- frame_posn  in  6  bit position within the 64-bit I2S frame, from the I2S clock block.
- sd_in  in  LINES  I2S serial data lines.
- enable  in  1  1 = capture may write RAM; 0 = host owns RAM.
- pattern  in  1  test-pattern select (used only with the optional feature).
- we  out  1  audio RAM write enable.
- waddr  out  CHAN_W+FRAME_W  RAM write address {chan, frame}.
- wdata  out  SAMPLE_W  RAM write data.
- frame  out  FRAME_W  current frame counter.
- frame_done  out  1  one-ck pulse after the last channel write of a frame.
- overrun  out  1  sticky: a frame completed while the previous burst was still writing.

Behaviour:
- Reset (rst=0, async): we, waddr, wdata, frame, frame_done, overrun, all shift and holding registers = 0; FSM = IDLE.
- Bit sampling:
  - sck is registered once (sck_d); a rising edge is sck & ~sck_d.
  - At each rising edge, frame_posn and every sd_in line are sampled.
- Slot mapping (I2S, one-bit delay):
  - Left word bits [15:0] are at frame_posn 1..16, MSB at 1.
  - Right word bits [15:0] are at frame_posn 33..48.
  - Bits at all other positions are ignored.
  - One shift register per line per side, shift-left.
- Frame completion: the sampled edge with frame_posn == 63 copies all 2*LINES words into holding registers and raises start for one ck.
- Channel numbering: chan = 2*line + side (left=0, right=1). Channels above 2*LINES-1 are not written.
- FSM:
  - IDLE: on start with enable=1, go to WRITE with chan=0. On start with enable=0, no action.
  - WRITE: each ck, we=1, waddr={chan, frame}, wdata=holding[chan], chan++. After chan == 2*LINES-1 is written, go to DONE.
  - DONE: one ck. frame_done=1, frame <= frame+1 (wraps 63 -> 0), back to IDLE.
- Latency: the first write is 1 ck after start; a burst is 2*LINES ck, then frame_done on the following ck.
- enable falls mid-burst: we=0 from the next ck, FSM returns to IDLE, no frame_done, frame does not advance.
- enable=0 in general: frame holds, shifters keep running, so capture resumes cleanly on the next complete frame after enable rises.
- start while in WRITE or DONE: holding registers are NOT overwritten (current burst completes with old data), the new frame is dropped, overrun <= 1. overrun clears only on reset.
- Outputs are registered. In IDLE: we=0; waddr and wdata hold their last value.
- Reset mid-burst: immediate abort, all outputs to reset values.

Optional Feature:
- Macro I2S_CAPTURE_PATTERN_EN.
- Defined: when pattern=1, wdata = {chan[3:0 zero-extended], frame[5:0], 6'h00}, i.e. wdata[15:12]=chan, wdata[11:6]=frame, low bits 0. Live sd_in data is ignored; timing and all other behaviour are unchanged.
- Not defined: pattern is unused and wdata is always captured data.

Test Plan:
- Reset release; drive line0 left=16'hA55A, right=16'h1234 in one frame -> after posn 63 edge: writes chan0=A55A at waddr {0,0}, chan1=1234 at {1,0}; frame_done pulses 1 ck after last write; frame=1.
- All 4 lines with distinct words (0x1111*k) over 64 consecutive frames -> 8 writes per frame, addresses {chan, f}; frame wraps 63->0 on the 64th frame_done.
- sd bits toggling at posn 0, 17..31, 49..63 -> captured words unaffected (e.g. still 16'hA55A).
- enable=0 for 3 frames, then 1 -> no we during disable, frame unchanged; next full frame writes at the held frame value.
- enable dropped after 3 writes of a burst -> at most one further we, no frame_done, frame unchanged. Separately, rst asserted mid-burst -> we=0 at once, frame=0.
- Force start during WRITE (sck divider reduced so frames are shorter than a burst) -> overrun=1 and stays 1; in-flight burst data unchanged. With I2S_CAPTURE_PATTERN_EN and pattern=1: chan5, frame9 -> wdata=16'h5240.

Source files
------------

// File: rtl/i2s_capture_if.sv
// i2s_capture_if: audio RAM write port plus frame status produced by the I2S capture block.
//   master (capture side) drives:  we, waddr {chan, frame}, wdata, frame, frame_done, overrun
//   slave  (audio engine side) receives the same signals as inputs.
interface i2s_capture_if #(
  parameter int CHAN_W   = 3,
  parameter int FRAME_W  = 6,
  parameter int SAMPLE_W = 16
);
  logic                      we;
  logic [CHAN_W+FRAME_W-1:0] waddr;
  logic [SAMPLE_W-1:0]       wdata;
  logic [FRAME_W-1:0]        frame;
  logic                      frame_done;
  logic                      overrun;

  modport master (output we, waddr, wdata, frame, frame_done, overrun);
  modport slave  (input  we, waddr, wdata, frame, frame_done, overrun);
endinterface

// File: rtl/i2s_capture.sv
// i2s_capture: deserialises up to 4 I2S data lines (2 mono channels each) into 16-bit
// samples and, once per frame, bursts one sample per channel into the audio input RAM
// at address {chan, frame}, then advances the frame counter and pulses frame_done.
//
// Ports:
//   ck          system clock (all logic on posedge)
//   rst         asynchronous active-low reset
//   sck         I2S bit clock, synchronous to ck
//   frame_posn  bit position within the 64-bit I2S frame
//   sd_in       I2S serial data, one bit per line
//   enable      1 = capture may write the RAM, 0 = host owns the RAM
//   pattern     test-pattern select (only with I2S_CAPTURE_PATTERN_EN)
//   bus         i2s_capture_if.master: we/waddr/wdata/frame/frame_done/overrun
//
// Optional build macro: I2S_CAPTURE_PATTERN_EN -- when defined and pattern=1, each write
// carries {chan, frame, zeros} instead of captured audio; timing is unchanged.
module i2s_capture #(
  parameter int LINES    = 4,
  parameter int CHAN_W   = 3,
  parameter int FRAME_W  = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sck,
  input  logic [5:0]       frame_posn,
  input  logic [LINES-1:0] sd_in,
  input  logic             enable,
  input  logic             pattern,
  i2s_capture_if.master    bus
);
  localparam int NCHAN = 2 * LINES;
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCHAN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t state, state_next;

  logic sck_d, sck_rise, frame_end, start;
  logic left_slot, right_slot;

  logic [SAMPLE_W-1:0] left_sh  [LINES];
  logic [SAMPLE_W-1:0] right_sh [LINES];
  logic [SAMPLE_W-1:0] holding  [NCHAN];

  logic [CHAN_W-1:0]         chan, chan_next, wr_chan;
  logic [SAMPLE_W-1:0]       wr_sample;
  logic                      we_next, frame_done_next;
  logic [CHAN_W+FRAME_W-1:0] waddr_next;
  logic [SAMPLE_W-1:0]       wdata_next;
  logic [FRAME_W-1:0]        frame_next;

  assign sck_rise  = sck & ~sck_d;
  assign frame_end = sck_rise && (frame_posn == 6'd63);
  // One-bit I2S delay: left word occupies posn 1..16, right word 33..48, MSB first.
  assign left_slot  = (frame_posn >= 6'd1)  && (frame_posn <= 6'd16);
  assign right_slot = (frame_posn >= 6'd33) && (frame_posn <= 6'd48);

  // Per-line shifters run regardless of enable so capture resumes on a clean frame.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        left_sh[i]  <= '0;
        right_sh[i] <= '0;
      end
    end else if (sck_rise) begin
      for (int i = 0; i < LINES; i++) begin
        if (left_slot)  left_sh[i]  <= {left_sh[i][SAMPLE_W-2:0], sd_in[i]};
        if (right_slot) right_sh[i] <= {right_sh[i][SAMPLE_W-2:0], sd_in[i]};
      end
    end
  end

  // Frame hand-off. A frame that ends while a burst is still in flight is dropped so
  // the burst keeps its own data; the loss is recorded in the sticky overrun flag.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      sck_d       <= 1'b0;
      start       <= 1'b0;
      bus.overrun <= 1'b0;
      for (int i = 0; i < NCHAN; i++) holding[i] <= '0;
    end else begin
      sck_d <= sck;
      start <= frame_end && (state == IDLE);
      if (frame_end && (state != IDLE)) bus.overrun <= 1'b1;
      if (frame_end && (state == IDLE)) begin
        for (int i = 0; i < LINES; i++) begin
          holding[2*i]   <= left_sh[i];
          holding[2*i+1] <= right_sh[i];
        end
      end
    end
  end

  // Channel that the next registered write will carry.
  assign wr_chan = (state == IDLE) ? '0 : chan + 1'b1;

  always_comb begin
    wr_sample = holding[wr_chan];
`ifdef I2S_CAPTURE_PATTERN_EN
    if (pattern) begin
      wr_sample = '0;
      wr_sample[SAMPLE_W-1 -: 4]       = 4'(wr_chan);
      wr_sample[SAMPLE_W-5 -: FRAME_W] = bus.frame;
    end
`endif
  end

`ifndef I2S_CAPTURE_PATTERN_EN
  logic unused_pattern;
  assign unused_pattern = pattern;
`endif

  always_comb begin
    state_next      = state;
    chan_next       = chan;
    we_next         = 1'b0;
    waddr_next      = bus.waddr;
    wdata_next      = bus.wdata;
    frame_next      = bus.frame;
    frame_done_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && enable) begin
          state_next = WRITE;
          chan_next  = wr_chan;
          we_next    = 1'b1;
          waddr_next = {wr_chan, bus.frame};
          wdata_next = wr_sample;
        end
      end
      WRITE: begin
        if (!enable) begin
          state_next = IDLE;          // abort: no frame_done, frame holds
        end else if (chan == LAST_CHAN) begin
          state_next      = DONE;
          frame_done_next = 1'b1;
          frame_next      = bus.frame + 1'b1;
        end else begin
          chan_next  = wr_chan;
          we_next    = 1'b1;
          waddr_next = {wr_chan, bus.frame};
          wdata_next = wr_sample;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      chan           <= '0;
      bus.we         <= 1'b0;
      bus.waddr      <= '0;
      bus.wdata      <= '0;
      bus.frame      <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_next;
      chan           <= chan_next;
      bus.we         <= we_next;
      bus.waddr      <= waddr_next;
      bus.wdata      <= wdata_next;
      bus.frame      <= frame_next;
      bus.frame_done <= frame_done_next;
    end
  end
endmodule
